// File: rtl/stream_bit_packer_if.sv
// AXI-stream style bus carrying a bit-count tkeep field; shared by the input
// and output sides of stream_bit_packer.
interface stream_bit_packer_if #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = 5
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tkeep, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tkeep, input  tlast, output tready);
endinterface

// File: rtl/stream_bit_packer.sv
// Densely packs bit-count-keyed 16-bit beats LSB-first into full words, flushing on tlast.
// Optional STREAM_BIT_PACKER_STATS_EN adds stat_words / stat_packets counters.
module stream_bit_packer #(
  parameter int DATA_W = 16,
  parameter int KEEP_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  stream_bit_packer_if.slave  input_bus,
  stream_bit_packer_if.master output_bus
`ifdef STREAM_BIT_PACKER_STATS_EN
  ,
  output logic [15:0]         stat_words,
  output logic [15:0]         stat_packets
`endif
);

  localparam int ACC_W  = 2 * DATA_W;
  localparam int FILL_W = KEEP_W + 1;

  typedef enum logic [1:0] {
    ACCUM,
    EMIT,
    FLUSH
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [KEEP_W-1:0]   out_keep_q, out_keep_d;
  logic                out_last_q, out_last_d;
  logic                out_valid_q, out_valid_d;
  logic                live_q;

  logic [KEEP_W-1:0]   k;
  logic [ACC_W-1:0]    masked;
  logic [FILL_W-1:0]   fill_sum;
  logic                slot_free;
  logic                in_ready;

  // live_q keeps input_tready low while reset is held, yet stays purely registered
  assign in_ready  = (state_q == ACCUM) && live_q;
  assign slot_free = !out_valid_q || output_bus.tready;

  assign input_bus.tready  = in_ready;
  assign output_bus.tdata  = out_data_q;
  assign output_bus.tkeep  = out_keep_q;
  assign output_bus.tlast  = out_last_q;
  assign output_bus.tvalid = out_valid_q;

  always_comb begin
    k = (input_bus.tkeep > KEEP_W'(DATA_W)) ? KEEP_W'(DATA_W) : input_bus.tkeep;
    masked = {{DATA_W{1'b0}}, input_bus.tdata} & ((ACC_W'(1) << k) - ACC_W'(1));
    fill_sum = fill_q + FILL_W'(k);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !output_bus.tready;

    unique case (state_q)
      ACCUM: begin
        if (input_bus.tvalid && in_ready) begin
          acc_d  = acc_q | (masked << fill_q);
          fill_d = fill_sum;
          if (input_bus.tlast) begin
            state_d = FLUSH;
          end else if (fill_sum >= FILL_W'(DATA_W)) begin
            state_d = EMIT;
          end
        end
      end

      EMIT: begin
        if (slot_free) begin
          out_data_d  = acc_q[DATA_W-1:0];
          out_keep_d  = KEEP_W'(DATA_W);
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          acc_d       = acc_q >> DATA_W;
          fill_d      = fill_q - FILL_W'(DATA_W);
          state_d     = ACCUM;
        end
      end

      FLUSH: begin
        if (slot_free) begin
          out_data_d  = acc_q[DATA_W-1:0];
          out_valid_d = 1'b1;
          if (fill_q > FILL_W'(DATA_W)) begin
            out_keep_d = KEEP_W'(DATA_W);
            out_last_d = 1'b0;
            acc_d      = acc_q >> DATA_W;
            fill_d     = fill_q - FILL_W'(DATA_W);
          end else begin
            // fill of 0..16 fits the keep field exactly, so an empty packet yields keep 0
            out_keep_d = fill_q[KEEP_W-1:0];
            out_last_d = 1'b1;
            acc_d      = '0;
            fill_d     = '0;
            state_d    = ACCUM;
          end
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      live_q      <= 1'b1;
    end
  end

`ifdef STREAM_BIT_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_words   <= '0;
      stat_packets <= '0;
    end else if (out_valid_q && output_bus.tready) begin
      stat_words <= stat_words + 16'd1;
      if (out_last_q) begin
        stat_packets <= stat_packets + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_bit_packer.sv
// Self-checking bench for stream_bit_packer: directed cases plus random packets
// checked against a bit-queue reference model.
module tb_stream_bit_packer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stream_bit_packer_if in_bus ();
  stream_bit_packer_if out_bus ();

`ifdef STREAM_BIT_PACKER_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_packets;
`endif

  stream_bit_packer #(.DATA_W(16), .KEEP_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .input_bus  (in_bus),
    .output_bus (out_bus)
`ifdef STREAM_BIT_PACKER_STATS_EN
    ,
    .stat_words   (stat_words),
    .stat_packets (stat_packets)
`endif
  );

  typedef struct {
    logic [15:0] d;
    logic [4:0]  k;
    logic        l;
  } word_t;

  word_t expq[$];
  bit    mbits[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    auto_model = 1'b0;
  bit    rand_ready = 1'b0;
  bit    accepted;
  bit    prev_stall = 1'b0;
  logic [15:0] prev_d;
  logic [4:0]  prev_k;
  logic        prev_l;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] d, input logic [4:0] k, input logic l);
    word_t w;
    w.d = d; w.k = k; w.l = l;
    expq.push_back(w);
  endtask

  task automatic pop_word(input int unsigned n, input logic l);
    logic [15:0] w;
    w = '0;
    for (int unsigned i = 0; i < n; i++) w[i] = mbits.pop_front();
    expect_word(w, 5'(n), l);
  endtask

  // Reference: a packet is a bit stream; full words leave as soon as 16 bits
  // are held, and tlast always closes the packet with a last-flagged word.
  task automatic model_beat(input logic [15:0] d, input logic [4:0] k, input logic l);
    int unsigned kk;
    kk = (k > 5'd16) ? 16 : int'(k);
    for (int unsigned i = 0; i < kk; i++) mbits.push_back(d[i]);
    if (!l) begin
      while (mbits.size() >= 16) pop_word(16, 1'b0);
    end else if (mbits.size() == 0) begin
      expect_word(16'h0000, 5'd0, 1'b1);
    end else begin
      while (mbits.size() > 16) pop_word(16, 1'b0);
      pop_word(mbits.size(), 1'b1);
    end
  endtask

  task automatic cycle();
    logic acc_hs, out_hs;
    logic [15:0] sd, bd;
    logic [4:0]  sk, bk;
    logic        sl, bl, sv;
    word_t       w;
    @(negedge clk);
    if (rand_ready) out_bus.tready = ($urandom_range(0, 3) != 0);
    acc_hs = (in_bus.tvalid === 1'b1) && (in_bus.tready === 1'b1);
    out_hs = (out_bus.tvalid === 1'b1) && (out_bus.tready === 1'b1);
    sd = out_bus.tdata; sk = out_bus.tkeep; sl = out_bus.tlast; sv = out_bus.tvalid;
    bd = in_bus.tdata;  bk = in_bus.tkeep;  bl = in_bus.tlast;
    if (prev_stall) begin
      check("hold_valid", 32'(sv), 32'd1);
      check("hold_data",  32'(sd), 32'(prev_d));
      check("hold_keep",  32'(sk), 32'(prev_k));
      check("hold_last",  32'(sl), 32'(prev_l));
    end
    prev_stall = (sv === 1'b1) && (out_bus.tready !== 1'b1);
    prev_d = sd; prev_k = sk; prev_l = sl;
    @(posedge clk);
    #1;
    accepted = 1'b0;
    if (reset) begin
      prev_stall = 1'b0;
      return;
    end
    accepted = acc_hs;
    if (acc_hs && auto_model) model_beat(bd, bk, bl);
    if (out_hs) begin
      if (expq.size() == 0) begin
        check("unexpected_word", 32'(sd), 32'hFFFF_FFFF);
      end else begin
        w = expq.pop_front();
        check("word_data", 32'(sd), 32'(w.d));
        check("word_keep", 32'(sk), 32'(w.k));
        check("word_last", 32'(sl), 32'(w.l));
      end
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic [4:0] k, input logic l);
    int unsigned n;
    in_bus.tdata  = d;
    in_bus.tkeep  = k;
    in_bus.tlast  = l;
    in_bus.tvalid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!accepted && n < 200);
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    in_bus.tvalid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    rand_ready = 1'b0;
    out_bus.tready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 500) begin
      cycle();
      n++;
    end
    for (int i = 0; i < 4; i++) cycle();
    check("drain_empty", 32'(expq.size()), 32'd0);
    check("idle_valid", 32'(out_bus.tvalid), 32'd0);
  endtask

  initial begin
    in_bus.tdata   = 16'hDEAD;
    in_bus.tkeep   = 5'd16;
    in_bus.tlast   = 1'b0;
    in_bus.tvalid  = 1'b1;
    out_bus.tready = 1'b1;

    // Reset held 3 cycles with a valid beat offered
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_in_ready", 32'(in_bus.tready),  32'd0);
      check("rst_valid",    32'(out_bus.tvalid), 32'd0);
      check("rst_data",     32'(out_bus.tdata),  32'd0);
      check("rst_keep",     32'(out_bus.tkeep),  32'd0);
      check("rst_last",     32'(out_bus.tlast),  32'd0);
    end
    in_bus.tvalid = 1'b0;
    reset = 1'b0;
    cycle();
    check("post_rst_ready", 32'(in_bus.tready), 32'd1);

    // Byte packing
    auto_model = 1'b0;
    expect_word(16'hBBAA, 5'd16, 1'b0);
    expect_word(16'hDDCC, 5'd16, 1'b0);
    expect_word(16'h00EE, 5'd8,  1'b1);
    send_beat(16'h00AA, 5'd8, 1'b0);
    send_beat(16'h00BB, 5'd8, 1'b0);
    send_beat(16'h00CC, 5'd8, 1'b0);
    send_beat(16'h00DD, 5'd8, 1'b0);
    send_beat(16'h00EE, 5'd8, 1'b1);
    drain();

    // Odd widths with a double flush
    expect_word(16'h3ABC, 5'd16, 1'b0);
    expect_word(16'h5612, 5'd16, 1'b0);
    expect_word(16'h0004, 5'd4,  1'b1);
    send_beat(16'h0ABC, 5'd12, 1'b0);
    send_beat(16'h0123, 5'd12, 1'b0);
    send_beat(16'h0456, 5'd12, 1'b1);
    drain();

    // Masking, clamp, empty packet
    expect_word(16'h000F, 5'd4,  1'b1);
    expect_word(16'h1234, 5'd16, 1'b1);
    expect_word(16'h0000, 5'd0,  1'b1);
    send_beat(16'hFFFF, 5'd4,  1'b1);
    send_beat(16'h1234, 5'd20, 1'b1);
    send_beat(16'hFFFF, 5'd0,  1'b1);
    drain();

    // Backpressure: first word stalls, second word pends behind it
    out_bus.tready = 1'b0;
    expect_word(16'hBBAA, 5'd16, 1'b0);
    expect_word(16'hDDCC, 5'd16, 1'b0);
    expect_word(16'h00EE, 5'd8,  1'b1);
    send_beat(16'h00AA, 5'd8, 1'b0);
    send_beat(16'h00BB, 5'd8, 1'b0);
    send_beat(16'h00CC, 5'd8, 1'b0);
    send_beat(16'h00DD, 5'd8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_valid",    32'(out_bus.tvalid), 32'd1);
      check("bp_data",     32'(out_bus.tdata),  32'h0000BBAA);
      check("bp_in_ready", 32'(in_bus.tready),  32'd0);
    end
    out_bus.tready = 1'b1;
    send_beat(16'h00EE, 5'd8, 1'b1);
    drain();

    // Random packets against the reference model, random downstream stalls
    auto_model = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int unsigned nb;
      nb = $urandom_range(1, 5);
      rand_ready = 1'b1;
      for (int unsigned b = 0; b < nb; b++) begin
        send_beat(16'($urandom), 5'($urandom_range(0, 20)), (b == nb - 1));
        for (int unsigned g = $urandom_range(0, 2); g > 0; g--) cycle();
      end
    end
    drain();
    check("model_residue", 32'(mbits.size()), 32'd0);

    // Reset mid-packet discards the partial packet, then a clean packet follows
    auto_model = 1'b0;
    out_bus.tready = 1'b0;
    send_beat(16'h00AA, 5'd8, 1'b0);
    send_beat(16'h00BB, 5'd8, 1'b0);
    send_beat(16'h00CC, 5'd8, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    out_bus.tready = 1'b1;
    cycle();
    check("midrst_valid", 32'(out_bus.tvalid), 32'd0);
    check("midrst_ready", 32'(in_bus.tready),  32'd1);
    expect_word(16'h3ABC, 5'd16, 1'b0);
    expect_word(16'h5612, 5'd16, 1'b0);
    expect_word(16'h0004, 5'd4,  1'b1);
    send_beat(16'h0ABC, 5'd12, 1'b0);
    send_beat(16'h0123, 5'd12, 1'b0);
    send_beat(16'h0456, 5'd12, 1'b1);
    drain();
`ifdef STREAM_BIT_PACKER_STATS_EN
    check("stat_words",   32'(stat_words),   32'd3);
    check("stat_packets", 32'(stat_packets), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_bit_packer.md
# stream_bit_packer

Downstream stage of the bit-count packetizer. It consumes 16-bit AXI-stream beats in which tkeep gives the number of valid LSBs (0..16). It densely packs those bits LSB-first into full 16-bit output words. On tlast it flushes the residue as a final partial word whose tkeep carries the residual bit count.

## Interface
- DATA_W, 16, data width in bits (only 16 is supported)
- KEEP_W, 5, width of the bit-count tkeep field
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- input_tdata  input  16  payload; only bits [tkeep-1:0] are meaningful
- input_tvalid  input  1  upstream beat valid
- input_tkeep  input  5  number of valid LSBs; values >16 are treated as 16
- input_tlast  input  1  last beat of packet
- input_tready  output  1  block accepts beat this cycle
- output_tdata  output  16  packed word, bits above tkeep are zero
- output_tvalid  output  1  output word valid
- output_tkeep  output  5  valid bit count of output word (16 except final word)
- output_tlast  output  1  final word of packet
- output_tready  input  1  downstream accepts word

## Operation
- Storage: 32-bit accumulator `acc`, 6-bit fill count `fill`, and one registered output slot.
- Invariant: fill < 16 whenever state = ACCUM.
- Input masking: `k = min(input_tkeep, 16)`. Data is ANDed with `(1<<k)-1` before use, so garbage above k never propagates.
- The output slot is free when `!output_tvalid || output_tready`.
- Output hold rule: data, keep and last on the output hold stable while `output_tvalid && !output_tready`.
- States:
  - **ACCUM**: input_tready = 1.
    - On accept: `acc |= masked << fill`, `fill += k`.
    - If input_tlast, go to FLUSH.
    - Otherwise, if the new fill ≥ 16, go to EMIT.
    - Otherwise stay in ACCUM.
  - **EMIT**: input_tready = 0. When the slot is free:
    - Load output with `acc[15:0]`, keep = 16, last = 0, valid = 1.
    - `acc >>= 16`, `fill -= 16`, go to ACCUM.
  - **FLUSH**: input_tready = 0. When the slot is free:
    - If fill > 16: emit `acc[15:0]` with keep = 16, last = 0, shift, stay in FLUSH.
    - Otherwise: emit `acc[15:0]` with keep = fill, last = 1; clear acc and fill; go to ACCUM.
- Boundary cases:
  - tlast with total fill = 0 (including a tkeep = 0 last beat) emits one word: data 0, keep 0, last 1. Packet boundaries are never lost.
  - tlast with fill exactly 16 emits a single word with keep 16, last 1.
  - Maximum fill is 15 + 16 = 31, so the 32-bit acc never overflows.
  - A tkeep = 0 beat without tlast is accepted and changes nothing.
- When output_tvalid = 1 and output_tready = 1 with no new load, output_tvalid drops to 0.
- Reset mid-packet: state goes to ACCUM, acc and fill clear, output slot empties. Partial packet bits are discarded without a tlast.

## Timing
- Reset values:
  - input_tready = 0 during reset; 1 in the first cycle after reset.
  - output_tdata, output_tvalid, output_tkeep, output_tlast are all 0.
- Latency: a word completed by the beat accepted at edge N is visible on the output after edge N+1.
- Throughput:
  - Sustained full-width input (tkeep = 16) runs at 1 beat per 2 cycles.
  - Beats with tkeep ≤ 8 run at ≥ 2 beats per 3 cycles.
- input_tready is a registered-state function only, with no combinational path from output_tready.
- output_tvalid never depends combinationally on input_tvalid.

## Configuration
- Macro `STREAM_BIT_PACKER_STATS_EN`.
- When defined, the block adds two output ports, both cleared by reset:
  - `stat_words` (output, 16): increments on every output handshake.
  - `stat_packets` (output, 16): increments on every handshake with output_tlast = 1.
  - Both counters wrap from 0xFFFF to 0.
- When undefined, neither port nor any counter logic exists. Packing behaviour is identical in both builds.

## Test plan
- **Reset:** assert reset 3 cycles with input_tvalid = 1 -> all outputs 0, no beat accepted. Release -> input_tready = 1 next cycle.
- **Byte packing:** beats 0xAA, 0xBB, 0xCC, 0xDD, 0xEE, all tkeep = 8, last on 0xEE -> outputs 0xBBAA/16/0, 0xDDCC/16/0, 0x00EE/8/1.
- **Odd widths with double flush:** beats 0x0ABC, 0x0123, 0x0456, tkeep = 12, last on 0x0456 -> outputs 0x3ABC/16/0, 0x5612/16/0, 0x0004/4/1.
- **Masking, clamp and empty packet:**
  - 0xFFFF with tkeep = 4, last -> 0x000F/4/1.
  - 0x1234 with tkeep = 20, last -> 0x1234/16/1.
  - tkeep = 0 with last on empty acc -> 0x0000/0/1.
- **Backpressure:** hold output_tready = 0 for 5 cycles while a word is valid -> output stable, input_tready = 0 once the next word is pending. No loss or duplication after release.
- **Reset mid-packet and stats (macro defined):**
  - Reset after 3 of 5 beats, then send scenario 2 -> only scenario 2 words appear.
  - stat_words = 3, stat_packets = 1.
